// File: rtl/redmule_mx_stream_decoder.sv
// Streaming MX (E4M3/E5M2 + E8M0 scale) to FP16 decoder with a 2-entry
// ping-pong input buffer and a registered, back-pressurable output beat.

module redmule_mx_lane (
  input  logic [7:0]  elem_i,
  input  logic        fmt_i,
  input  logic [7:0]  scale_i,
  output logic [15:0] fp16_o
);
  logic [15:0]       h;
  logic [3:0]        e4;
  logic [2:0]        m3;
  logic signed [9:0] en, ep;
  logic [9:0]        mn;

  always_comb begin
    e4 = elem_i[6:3];
    m3 = elem_i[2:0];
    if (fmt_i) h = {elem_i, 8'h00};
    else if (e4 == 4'd0) begin
      // E4M3 subnormals land on FP16 normals: exponent tracks the leading one
      if (m3[2])      h = {elem_i[7], 5'd8, m3[1:0], 8'h00};
      else if (m3[1]) h = {elem_i[7], 5'd7, m3[0], 9'h000};
      else if (m3[0]) h = {elem_i[7], 5'd6, 10'h000};
      else            h = {elem_i[7], 15'h0000};
    end
    else if (elem_i[6:0] == 7'h7F) h = 16'h7E00;
    else h = {elem_i[7], {1'b0, e4} + 5'd8, m3, 7'h00};
  end

  always_comb begin
    en = $signed({5'd0, h[14:10]});
    mn = h[9:0];
    if (h[14:10] == 5'd0) begin
      for (int k = 0; k < 10; k++) begin
        if (h[k]) begin
          en = 10'(k - 9);
          mn = h[9:0] << (10 - k);
        end
      end
    end
    ep = en + $signed({2'b00, scale_i}) - 10'sd127;
    if (scale_i == 8'hFF)                               fp16_o = 16'h7E00;
    else if (h[14:10] == 5'd31 || h[14:0] == 15'd0)    fp16_o = h;
    else if (ep >= 10'sd31)                             fp16_o = {h[15], 15'h7BFF};
    else if (ep <= 10'sd0)                              fp16_o = {h[15], 15'h0000};
    else                                                fp16_o = {h[15], ep[4:0], mn};
  end
endmodule

module redmule_mx_stream_decoder #(
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned BITW         = 16,
  parameter int unsigned NUM_LANES    = 1,
  parameter int unsigned MX_EXP_WIDTH = (DATA_W/8/NUM_LANES)*8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      mx_val_valid_i,
  output logic                      mx_val_ready_o,
  input  logic [DATA_W-1:0]         mx_val_data_i,
  input  logic                      mx_fmt_i,
  input  logic                      mx_exp_valid_i,
  output logic                      mx_exp_ready_o,
  input  logic [MX_EXP_WIDTH-1:0]   mx_exp_data_i,
  input  logic                      vector_shared_exp_i,
  output logic                      fp16_valid_o,
  input  logic                      fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] fp16_data_o,
  output logic                      fp16_last_o,
  output logic                      busy_o
);
  localparam int unsigned NUM_GROUPS = DATA_W/8/NUM_LANES;
  localparam int unsigned GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  if (MX_EXP_WIDTH != NUM_GROUPS*8) begin : g_bad_exp
    $fatal(1, "MX_EXP_WIDTH must be 8 bits per group");
  end
  if (DATA_W % (8*NUM_LANES) != 0) begin : g_bad_lanes
    $fatal(1, "NUM_LANES must divide DATA_W/8");
  end
  if (BITW != 16) begin : g_bad_bitw
    $fatal(1, "BITW is fixed at 16");
  end

  logic [DATA_W-1:0]       buf_data [2];
  logic [MX_EXP_WIDTH-1:0] buf_exp  [2];
  logic [1:0]              buf_fmt, buf_vec;
  logic                    head, tail;
  logic [1:0]              cnt;
  logic [GW-1:0]           grp;

  logic                    in_ready, push, bypass, src_valid, out_free, load, pop, grp_last;
  logic [DATA_W-1:0]       src_data;
  logic [MX_EXP_WIDTH-1:0] src_exp;
  logic                    src_fmt, src_vec;
  logic [NUM_LANES*8-1:0]  grp_bytes;
  logic [7:0]              scale;
  logic [NUM_LANES-1:0][BITW-1:0] conv;

  assign in_ready       = (cnt != 2'd2) && !clear_i;
  assign mx_val_ready_o = in_ready;
  assign mx_exp_ready_o = in_ready;
  assign push           = mx_val_valid_i && mx_exp_valid_i && in_ready;

  // Empty buffer: decode straight from the input so the first beat costs one cycle
  assign bypass    = (cnt == 2'd0);
  assign src_data  = bypass ? mx_val_data_i       : buf_data[head];
  assign src_exp   = bypass ? mx_exp_data_i       : buf_exp[head];
  assign src_fmt   = bypass ? mx_fmt_i            : buf_fmt[head];
  assign src_vec   = bypass ? vector_shared_exp_i : buf_vec[head];
  assign src_valid = !bypass || push;

  assign grp_bytes = src_data[grp*NUM_LANES*8 +: NUM_LANES*8];
  assign scale     = src_vec ? src_exp[grp*8 +: 8] : src_exp[7:0];
  assign grp_last  = (grp == GW'(NUM_GROUPS-1));
  assign out_free  = !fp16_valid_o || fp16_ready_i;
  assign load      = src_valid && out_free;
  assign pop       = load && grp_last;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    redmule_mx_lane u_lane (
      .elem_i  (grp_bytes[8*i +: 8]),
      .fmt_i   (src_fmt),
      .scale_i (scale),
      .fp16_o  (conv[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < 2; e++) begin
        buf_data[e] <= '0;
        buf_exp[e]  <= {NUM_GROUPS{8'd127}};
      end
      buf_fmt      <= '0;
      buf_vec      <= '0;
      head         <= 1'b0;
      tail         <= 1'b0;
      cnt          <= 2'd0;
      grp          <= '0;
      fp16_valid_o <= 1'b0;
      fp16_data_o  <= '0;
      fp16_last_o  <= 1'b0;
    end else if (clear_i) begin
      head         <= 1'b0;
      tail         <= 1'b0;
      cnt          <= 2'd0;
      grp          <= '0;
      fp16_valid_o <= 1'b0;
    end else begin
      if (push) begin
        buf_data[tail] <= mx_val_data_i;
        buf_exp[tail]  <= mx_exp_data_i;
        buf_fmt[tail]  <= mx_fmt_i;
        buf_vec[tail]  <= vector_shared_exp_i;
        tail           <= ~tail;
      end
      if (load) grp <= grp_last ? '0 : grp + 1'b1;
      if (pop)  head <= ~head;
      cnt <= cnt + 2'(push) - 2'(pop);
      if (out_free) begin
        fp16_valid_o <= src_valid;
        if (src_valid) begin
          fp16_data_o <= conv;
          fp16_last_o <= pop;
        end
      end
    end
  end

  assign busy_o = (cnt != 2'd0) || fp16_valid_o;
endmodule

// File: tb/tb_redmule_mx_stream_decoder.sv
// Scoreboard bench for redmule_mx_stream_decoder, DATA_W=64 / NUM_LANES=2 (4 groups).
module tb_redmule_mx_stream_decoder;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  logic        clk, rst_n, clear;
  logic        val_valid, val_ready, exp_valid, exp_ready, fmt, vec;
  logic [63:0] val_data;
  logic [31:0] exp_data;
  logic        fp16_valid, fp16_ready, fp16_last, busy;
  logic [31:0] fp16_data;

  beat_t expq[$];
  int    beat_cyc[$];
  int    n_vec = 0, n_miss = 0, cyc = 0;

  redmule_mx_stream_decoder #(.DATA_W(64), .BITW(16), .NUM_LANES(2), .MX_EXP_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .mx_val_valid_i(val_valid), .mx_val_ready_o(val_ready), .mx_val_data_i(val_data),
    .mx_fmt_i(fmt), .mx_exp_valid_i(exp_valid), .mx_exp_ready_o(exp_ready),
    .mx_exp_data_i(exp_data), .vector_shared_exp_i(vec),
    .fp16_valid_o(fp16_valid), .fp16_ready_i(fp16_ready), .fp16_data_o(fp16_data),
    .fp16_last_o(fp16_last), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every accepted output beat is checked against the queue head
  always @(negedge clk) begin
    if (rst_n && fp16_valid && fp16_ready) begin
      beat_t e;
      n_vec++;
      beat_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_beat: got data=%h last=%b, none expected", fp16_data, fp16_last);
      end else begin
        e = expq.pop_front();
        if (fp16_data !== e.data || fp16_last !== e.last) begin
          n_miss++;
          $display("FAIL beat: got data=%h last=%b want data=%h last=%b",
                   fp16_data, fp16_last, e.data, e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // eb is {g3, g2, g1, g0}; last is set on g3
  task automatic send(input logic [63:0] w, input logic f, input logic v,
                      input logic [31:0] ex, input logic [3:0][31:0] eb);
    int n = 0;
    @(negedge clk);
    val_data = w; fmt = f; vec = v; exp_data = ex;
    val_valid = 1'b1; exp_valid = 1'b1;
    while (!val_ready && n < 100) begin @(negedge clk); n++; end
    if (!val_ready) begin
      chk("send_timeout", 32'(val_ready), 32'd1);
    end else begin
      @(posedge clk);
      for (int g = 0; g < 4; g++) expq.push_back('{data: eb[g], last: (g == 3)});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    val_valid = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_left", expq.size(), 32'd0);
    @(negedge clk);
  endtask

  localparam logic [63:0] V1 = 64'h060C80007F7E0138;  // E4M3, scale 127
  localparam logic [63:0] V2 = 64'hF80003787FB80238;  // E4M3, scale 128
  localparam logic [63:0] V3 = 64'h7BFC027E80017C3C;  // E5M2, scale 130
  localparam logic [63:0] V4 = 64'h80127F00B838387E;  // E4M3, per-group 137/100/100/FF
  localparam logic [3:0][31:0] E1 = {32'h22002600, 32'h80000000, 32'h7E005F00, 32'h18003C00};
  localparam logic [3:0][31:0] E2 = {32'hE0000000, 32'h22006000, 32'h7E00C000, 32'h20004000};
  localparam logic [3:0][31:0] E3 = {32'h7BFFFC00, 32'h0C007E00, 32'h80000800, 32'h7C004800};
  localparam logic [3:0][31:0] E4 = {32'h7E007E00, 32'h7E000000, 32'h80000000, 32'h64007BFF};

  initial begin
    rst_n = 1'b0; clear = 1'b0; val_valid = 1'b0; exp_valid = 1'b0;
    val_data = '0; exp_data = '0; fmt = 1'b0; vec = 1'b0; fp16_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(fp16_valid), 32'd0);
    chk("rst_data",  fp16_data,       32'd0);
    chk("rst_last",  32'(fp16_last),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {30'd0, val_ready, exp_ready}, 32'd3);

    // Either valid alone must not transfer
    val_valid = 1'b1; val_data = V1;
    repeat (3) @(negedge clk);
    val_valid = 1'b0; exp_valid = 1'b1;
    repeat (3) @(negedge clk);
    exp_valid = 1'b0;
    @(negedge clk);
    chk("one_valid_busy", 32'(busy), 32'd0);

    // Conversion vectors; first one also measures first-beat latency
    send(V1, 1'b0, 1'b0, 32'hFF00007F, E1);
    idle();
    chk("latency_valid", 32'(fp16_valid), 32'd1);
    drain();
    send(V2, 1'b0, 1'b0, 32'h01020380, E2);
    send(V3, 1'b1, 1'b0, 32'h11223382, E3);
    send(V4, 1'b0, 1'b1, 32'hFF646489, E4);
    idle();
    drain();

    // Back-to-back words, per-group scales 2^g
    beat_cyc.delete();
    send(64'h3838383838383838, 1'b0, 1'b1, 32'h8281807F,
         {32'h48004800, 32'h44004400, 32'h40004000, 32'h3C003C00});
    send(64'h4040404040404040, 1'b1, 1'b1, 32'h8281807F,
         {32'h4C004C00, 32'h48004800, 32'h44004400, 32'h40004000});
    idle();
    drain();
    chk("b2b_beats", beat_cyc.size(), 32'd8);
    chk("b2b_span", (beat_cyc.size() == 8) ? 32'(beat_cyc[7] - beat_cyc[0]) : 32'hFFFFFFFF, 32'd7);

    // Backpressure: output held, buffer full refuses the third word
    @(posedge clk); #1 fp16_ready = 1'b0;
    send(V1, 1'b0, 1'b0, 32'h0000007F, E1);
    send(V2, 1'b0, 1'b0, 32'h00000080, E2);
    fork
      send(V3, 1'b1, 1'b0, 32'h00000082, E3);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #1;
          chk("bp_data",  fp16_data,        32'h18003C00);
          chk("bp_last",  32'(fp16_last),   32'd0);
          chk("bp_valid", 32'(fp16_valid),  32'd1);
          chk("bp_full_ready", 32'(val_ready), 32'd0);
        end
        @(posedge clk); #1 fp16_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Clear on the second beat with a competing input word
    send(V4, 1'b0, 1'b1, 32'hFF646489, E4);
    idle();
    @(negedge clk);
    clear = 1'b1; val_valid = 1'b1; exp_valid = 1'b1; val_data = V1; exp_data = 32'h7F;
    #1 chk("clr_ready", 32'(val_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0; val_valid = 1'b0; exp_valid = 1'b0;
    #1;
    chk("clr_valid", 32'(fp16_valid), 32'd0);
    chk("clr_busy",  32'(busy),       32'd0);
    chk("clr_dropped", expq.size(),   32'd2);
    expq.delete();
    repeat (4) @(negedge clk);
    chk("clr_busy_after", 32'(busy), 32'd0);

    // Reset mid-word
    send(V2, 1'b0, 1'b0, 32'h80, E2);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(fp16_valid), 32'd0);
    chk("mid_rst_data",  fp16_data,       32'd0);
    chk("mid_rst_last",  32'(fp16_last),  32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    expq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {30'd0, val_ready, exp_ready}, 32'd3);
    send(V1, 1'b0, 1'b0, 32'h7F, E1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
